// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- CPU data-memory port bundle.
//   master (CPU side):  drives mem_r, mem_w, addr, wdata, dm_ctrl;
//                       receives rdata, ready, addr_err, busy.
//   slave  (memory):    the reverse.
//   mem_r/mem_w  load/store request, held by the initiator until ready
//   addr         byte address
//   wdata        store data, right-aligned
//   dm_ctrl      000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
//   rdata        load data, right-aligned, zero-filled
//   ready        one-cycle completion pulse
//   addr_err     pulses with ready on a misaligned access or illegal dm_ctrl
//   busy         access in flight
interface dmem_responder_if;
    logic        mem_r;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  dm_ctrl;
    logic [31:0] rdata;
    logic        ready;
    logic        addr_err;
    logic        busy;

    modport master (
        output mem_r, mem_w, addr, wdata, dm_ctrl,
        input  rdata, ready, addr_err, busy
    );

    modport slave (
        input  mem_r, mem_w, addr, wdata, dm_ctrl,
        output rdata, ready, addr_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- slave end of the CPU data-memory port.
// Word-organised RAM built from byte lanes, word/half/byte stores with lane
// masking, right-aligned zero-filled loads, WAIT_CYCLES wait states, and a
// one-cycle ready pulse (with addr_err on misaligned/illegal accesses).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    dmem_responder_if.slave (request in, rdata/ready/addr_err/busy out)
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    localparam int         NUM_LANES = 4;
    localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);

    localparam logic [2:0] C_WORD  = 3'b000;
    localparam logic [2:0] C_HALF  = 3'b001;
    localparam logic [2:0] C_HALFU = 3'b010;
    localparam logic [2:0] C_BYTE  = 3'b011;
    localparam logic [2:0] C_BYTEU = 3'b100;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic          store;
        logic [AW-1:0] widx;
        logic [1:0]    ofs;
        logic [31:0]   wdata;
        logic [2:0]    ctrl;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    req_t        req;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        busy_q;

    logic                           err;
    logic                           commit;
    logic [NUM_LANES-1:0]           lane_we;
    logic [NUM_LANES-1:0][7:0]      lane_wd;
    logic [NUM_LANES-1:0][7:0]      rd_word;
    logic [31:0]                    load_data;

    // Address bits above the word index alias the array.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:AW+2]};

    // The access is performed on the final BUSY edge.
    assign commit = (state == BUSY) && (cnt == 4'd0);

    // Decode of the latched request: error check, lane enables and lane data.
    always_comb begin
        err       = 1'b0;
        lane_we   = '0;
        lane_wd   = req.wdata;
        load_data = '0;
        case (req.ctrl)
            C_WORD: begin
                err       = (req.ofs != 2'b00);
                lane_we   = 4'b1111;
                load_data = rd_word;
            end
            C_HALF, C_HALFU: begin
                err       = req.ofs[0];
                lane_we   = req.ofs[1] ? 4'b1100 : 4'b0011;
                lane_wd   = {2{req.wdata[15:0]}};
                load_data = {16'h0, req.ofs[1] ? rd_word[3:2] : rd_word[1:0]};
            end
            C_BYTE, C_BYTEU: begin
                lane_we   = 4'b0001 << req.ofs;
                lane_wd   = {4{req.wdata[7:0]}};
                load_data = {24'h0, rd_word[req.ofs]};
            end
            default: err = 1'b1;
        endcase
        if (!req.store || err) lane_we = '0;
    end

    // Byte-lane RAMs; contents are not reset.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [7:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (commit && lane_we[g]) mem[req.widx] <= lane_wd[g];
        end
        assign rd_word[g] = mem[req.widx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req     <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.mem_r || bus.mem_w) begin
                        state     <= BUSY;
                        busy_q    <= 1'b1;
                        cnt       <= WAIT_LD;
                        // Simultaneous read and write is treated as a store.
                        req.store <= bus.mem_w;
                        req.widx  <= bus.addr[AW+1:2];
                        req.ofs   <= bus.addr[1:0];
                        req.wdata <= bus.wdata;
                        req.ctrl  <= bus.dm_ctrl;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= err;
                        rdata_q <= (req.store || err) ? 32'h0 : load_data;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.addr_err = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: spec vectors, randomized accesses against a
// byte-array reference model, back-to-back re-sampling, and reset mid-access.
module tb_dmem_responder;
    localparam int WAIT = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH(1024), .AW(10), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference memory: one byte per location of the 4 KiB aliased space.
    logic [7:0] mm [4096];

    function automatic void model(input logic w, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [2:0] c,
                                  output logic [31:0] rd, output logic er);
        int b, size;
        b    = int'(a % 32'd4096);
        size = (c == 3'd0) ? 4 : (c <= 3'd2) ? 2 : 1;
        er   = (c > 3'd4) || (b % size != 0);
        rd   = 32'h0;
        if (er) return;
        for (int i = 0; i < size; i++) begin
            if (w) mm[b+i] = wd[8*i +: 8];
            else   rd[8*i +: 8] = mm[b+i];
        end
    endfunction

    // Drives one request, holds it until ready (bounded), returns response.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] c,
                          output logic [31:0] rd, output logic er,
                          output int lat, output logic bsy1);
        @(negedge clk);
        bus.mem_r = r; bus.mem_w = w; bus.addr = a; bus.wdata = wd; bus.dm_ctrl = c;
        lat = -1; bsy1 = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (n == 1) bsy1 = bus.busy;
            if (bus.ready) begin lat = n; break; end
        end
        rd = bus.rdata; er = bus.addr_err;
        @(negedge clk);
        bus.mem_r = 1'b0; bus.mem_w = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({bus.rdata, bus.ready, bus.addr_err, bus.busy} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdata=%h rdy=%b err=%b busy=%b, want all 0",
                     bus.rdata, bus.ready, bus.addr_err, bus.busy);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_spec_vectors();
        logic        vr [17] = '{0,1,0,1,1,0,1,1,1,0,1,0,1,1,1,0,1};
        logic        vw [17] = '{1,0,1,0,0,1,0,0,0,1,0,1,0,1,0,1,0};
        logic [31:0] va [17] = '{32'h10,32'h10,32'h11,32'h11,32'h10,32'h12,32'h12,32'h10,
                                 32'h13,32'h10,32'h10,32'h1010,32'h10,32'h14,32'h14,32'h15,32'h17};
        logic [31:0] vd [17] = '{32'hDEADBEEF,0,32'hAA,0,0,32'h1234,0,0,0,32'hFFFFFFFF,0,
                                 32'h5,0,32'hCAFEF00D,0,32'h7777,0};
        logic [2:0]  vc [17] = '{0,0,3,4,0,1,1,0,0,7,0,0,0,0,0,1,3};
        logic [31:0] xr [17] = '{0,32'hDEADBEEF,0,32'hAA,32'hDEADAAEF,0,32'h1234,32'h1234AAEF,
                                 0,0,32'h1234AAEF,0,32'h5,0,32'hCAFEF00D,0,32'hCA};
        logic        xe [17] = '{0,0,0,0,0,0,0,0,1,1,0,0,0,0,0,1,0};
        logic [31:0] rd, mrd;
        logic        er, mer, b1;
        int          lat;
        for (int i = 0; i < 17; i++) begin
            access(vr[i], vw[i], va[i], vd[i], vc[i], rd, er, lat, b1);
            model(vw[i], va[i], vd[i], vc[i], mrd, mer);
            n_cmp++;
            if (rd !== xr[i] || er !== xe[i]) begin
                n_bad++;
                $display("FAIL spec_vec[%0d]: got rdata=%h err=%b, want rdata=%h err=%b",
                         i, rd, er, xr[i], xe[i]);
            end
            n_cmp++;
            if (lat !== WAIT + 2 || b1 !== 1'b1) begin
                n_bad++;
                $display("FAIL spec_lat[%0d]: got lat=%0d busy=%b, want lat=%0d busy=1",
                         i, lat, b1, WAIT + 2);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, a, wd;
        logic        er, mer, b1, r, w;
        logic [2:0]  c;
        int          lat;
        // Fill bytes 0..63 so every later load has a defined model value.
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            access(1'b0, 1'b1, 32'(i * 4), wd, 3'd0, rd, er, lat, b1);
            model(1'b1, 32'(i * 4), wd, 3'd0, mrd, mer);
        end
        for (int i = 0; i < 80; i++) begin
            a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            wd = $urandom;
            c  = 3'($urandom_range(0, 7));
            w  = 1'($urandom);
            r  = w ? 1'($urandom) : 1'b1;
            access(r, w, a, wd, c, rd, er, lat, b1);
            model(w, a, wd, c, mrd, mer);
            n_cmp++;
            if (rd !== mrd || er !== mer || lat !== WAIT + 2) begin
                n_bad++;
                $display("FAIL rand[%0d] r=%b w=%b a=%h c=%0d: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                         i, r, w, a, c, rd, er, lat, mrd, mer, WAIT + 2);
            end
        end
    endtask

    // A load held through the RESP cycle is taken again as a fresh access.
    task automatic test_back_to_back();
        logic [31:0] mrd;
        logic        mer;
        int          n1, n2;
        logic        gap_ok;
        model(1'b0, 32'h10, 32'h0, 3'd0, mrd, mer);
        @(negedge clk);
        bus.mem_r = 1'b1; bus.mem_w = 1'b0; bus.addr = 32'h10; bus.dm_ctrl = 3'd0;
        n1 = -1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (bus.ready) begin n1 = n; break; end
        end
        n_cmp++;
        if (n1 !== WAIT + 2 || bus.rdata !== mrd) begin
            n_bad++;
            $display("FAIL b2b_first: got lat=%0d rdata=%h, want lat=%0d rdata=%h",
                     n1, bus.rdata, WAIT + 2, mrd);
        end
        n2 = -1; gap_ok = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk); #1;
            if (bus.ready) begin n2 = n; break; end
        end
        if (n2 > 1) gap_ok = 1'b1; else gap_ok = 1'b0;
        n_cmp++;
        if (n2 !== WAIT + 3 || !gap_ok || bus.rdata !== mrd) begin
            n_bad++;
            $display("FAIL b2b_second: got gap=%0d rdata=%h, want gap=%0d rdata=%h",
                     n2, bus.rdata, WAIT + 3, mrd);
        end
        @(negedge clk);
        bus.mem_r = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: got ready=%b busy=%b, want 0 0", bus.ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd, mrd;
        logic        er, mer, b1, saw_ready;
        int          lat;
        @(negedge clk);
        bus.mem_r = 1'b0; bus.mem_w = 1'b1; bus.addr = 32'h20;
        bus.wdata = 32'h2222_2222; bus.dm_ctrl = 3'd0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.rdata, bus.ready, bus.addr_err, bus.busy} !== 35'h0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got rdata=%h rdy=%b err=%b busy=%b, want all 0",
                     bus.rdata, bus.ready, bus.addr_err, bus.busy);
        end
        bus.mem_w = 1'b0;
        saw_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (bus.ready) saw_ready = 1'b1;
        end
        @(negedge clk); reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            if (bus.ready || bus.busy) saw_ready = 1'b1;
        end
        n_cmp++;
        if (saw_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_ready: got ready/busy activity=%b, want 0", saw_ready);
        end
        // The dropped store must not reach the array.
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'd0, rd, er, lat, b1);
        model(1'b0, 32'h20, 32'h0, 3'd0, mrd, mer);
        n_cmp++;
        if (rd !== mrd || er !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_data: got rdata=%h err=%b, want rdata=%h err=0", rd, er, mrd);
        end
    endtask

    initial begin
        bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.wdata = '0; bus.dm_ctrl = '0;
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
